slow_to_fast_cdc_rx: RTL and testbench
======================================

Name: slow_to_fast_cdc_rx

Overview:
Receives a stretched valid level plus a data bus launched from a slow domain (e.g. I2S SCLK) and brings them into Clk_Fast. It is the inverse path of the fast-to-slow pulse extender.
- Valid path: multi-flop synchronizer → rising-edge detect → settle counter → data capture into a one-entry valid/ready output register.
- Also reports glitches, overflow and a count of accepted samples.

Parameters:
DATA_W, 24, width of Slow_Data / Out_Data
SYNC_STAGES, 2, flops in valid synchronizer (legal ≥2)
SETTLE_CYCLES, 2, Clk_Fast cycles valid must stay high after edge detect before data capture (legal ≥1)
CNT_W, 16, width of Sample_Cnt

Ports:
Clk_Fast  in  1  fast system clock; the only clock
Rst  in  1  synchronous, active-high reset, sampled on Clk_Fast
Slow_Valid  in  1  async level from slow domain; high ≥ SYNC_STAGES+SETTLE_CYCLES+2 fast cycles per sample
Slow_Data  in  DATA_W  async bus, stable while Slow_Valid high; not synchronized
Out_Ready  in  1  downstream accepts Out_Data
Overflow_Clr  in  1  clears Overflow
Out_Data  out  DATA_W  captured sample
Out_Valid  out  1  Out_Data holds an unconsumed sample
Overflow  out  1  sticky: sample dropped because output was full
Glitch  out  1  one-cycle pulse: valid fell during SETTLE
Busy  out  1  FSM not in IDLE
Sample_Cnt  out  CNT_W  accepted captures, wraps at 2^CNT_W

Behaviour:
- Reset (synchronous): sync chain=0, state=IDLE, settle counter=0. Outputs Out_Data=0, Out_Valid=0, Overflow=0, Glitch=0, Busy=0, Sample_Cnt=0. Edge-detect prev register resets to 1, so a Slow_Valid already high at reset release is ignored until it goes low.
- sync_out = last synchronizer stage. rise = sync_out & ~prev. prev <= sync_out every cycle.
- FSM states: IDLE, SETTLE, WAIT_LOW.
  - IDLE: rise → SETTLE, cnt<=0.
  - SETTLE, sync_out=0: → IDLE, Glitch=1 for one cycle, no capture.
  - SETTLE, sync_out=1, cnt==SETTLE_CYCLES-1: capture, → WAIT_LOW.
  - SETTLE, otherwise: cnt++.
  - WAIT_LOW: sync_out=0 → IDLE. No re-trigger until then.
- Latency: if Slow_Valid is first sampled high at edge k, Out_Valid is high after edge k+SYNC_STAGES+SETTLE_CYCLES (default 4).
- Capture: Slow_Data is sampled directly at the capture edge.
  - Output empty, or Out_Ready=1 the same cycle: Out_Data<=Slow_Data, Out_Valid<=1, Sample_Cnt++.
  - Out_Valid=1 and Out_Ready=0: data dropped, Out_Data unchanged, Overflow<=1, Sample_Cnt unchanged.
- Handshake: Out_Valid&Out_Ready with no capture → Out_Valid<=0 next edge, Out_Data holds. Out_Ready while Out_Valid=0 is ignored.
- Overflow: cleared by Overflow_Clr; if set and clear occur together, set wins.
- Sample_Cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Busy = (state != IDLE).
- Reset mid-SETTLE or mid-WAIT_LOW: pending capture discarded, no Glitch pulse.

Decomposition:
- Shared package cdc_pkg:
  - rx_state_t enum {IDLE, SETTLE, WAIT_LOW}
  - default SYNC_STAGES constant
  - a DATA_W default matching the I2S sample width
- One sub-module, cdc_sync_bit: parameterized SYNC_STAGES flop chain with synchronous reset to 0. Reusable for other single-bit crossings.

Test Plan:
- Slow_Valid high 20 cycles, Slow_Data=24'hA5A5A5, Out_Ready=1 → Out_Valid at edge k+4, Out_Data=A5A5A5, Sample_Cnt=1, no Glitch/Overflow.
- Slow_Valid high 3 cycles only (drops during SETTLE) → one Glitch pulse, Out_Valid stays 0, FSM back to IDLE, Sample_Cnt=0.
- Two samples (0x111111, 0x222222), Out_Ready=0 throughout → Out_Data=0x111111, Overflow=1, Sample_Cnt=1. Pulse Overflow_Clr → Overflow=0.
- Out_Valid=1 with Out_Ready=1 on the exact capture edge of the next sample → Out_Valid stays 1, Out_Data=new value, Overflow=0, Sample_Cnt=2.
- Slow_Valid held high across reset release, then low 10 cycles, then high → only the second rise captured, Sample_Cnt=1.
- Rst asserted in SETTLE → outputs return to reset values next edge, no Glitch. With CNT_W=4, 16 captures → Sample_Cnt wraps to 0.

Source files
------------

// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// cdc_pkg: shared types and defaults for slow-to-fast domain crossings.
// Rev 1.0
// ============================================================================
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int I2S_DATA_W      = 24;

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// cdc_sync_bit: single-bit multi-flop synchronizer, synchronous reset to 0.
// Rev 1.0
// ============================================================================
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/slow_to_fast_cdc_rx.sv
`default_nettype none
// ============================================================================
// slow_to_fast_cdc_rx: captures a slow-domain valid level + data bus into the
// fast clock domain and presents it through a one-entry valid/ready register.
// Rev 1.0
// ============================================================================
module slow_to_fast_cdc_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W        = I2S_DATA_W,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              Clk_Fast,
  input  logic              Rst,
  input  logic              Slow_Valid,
  input  logic [DATA_W-1:0] Slow_Data,
  input  logic              Out_Ready,
  input  logic              Overflow_Clr,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  output logic              Overflow,
  output logic              Glitch,
  output logic              Busy,
  output logic [CNT_W-1:0]  Sample_Cnt
);

  localparam int                SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam int                FILL_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

  logic              sync_out;
  logic              prev_q;
  logic              rise;
  logic [FILL_W-1:0] fill_q;
  rx_state_t         state_q, state_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;
  logic              capture;
  logic              glitch_q, glitch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  samp_q, samp_d;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_valid (
    .clk_i (Clk_Fast),
    .rst_i (Rst),
    .d_i   (Slow_Valid),
    .q_o   (sync_out)
  );

  // The chain restarts at 0 after reset; hold prev high until the chain
  // reflects the real input so a level already high is not seen as a rise.
  always_ff @(posedge Clk_Fast) begin
    if (Rst) begin
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
      prev_q <= (fill_q == FILL_MAX) ? sync_out : 1'b1;
    end
  end

  assign rise = sync_out & ~prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!sync_out) begin
          state_d  = IDLE;
          glitch_d = 1'b1;
        end else if (cnt_q == SET_LAST) begin
          capture = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!sync_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    samp_d  = samp_q;
    if (Overflow_Clr) begin
      ovf_d = 1'b0;
    end
    if (valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      if (!valid_q || Out_Ready) begin
        data_d  = Slow_Data;
        valid_d = 1'b1;
        samp_d  = samp_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_Fast) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      samp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      samp_q   <= samp_d;
    end
  end

  assign Out_Data   = data_q;
  assign Out_Valid  = valid_q;
  assign Overflow   = ovf_q;
  assign Glitch     = glitch_q;
  assign Busy       = (state_q != IDLE);
  assign Sample_Cnt = samp_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_to_fast_cdc_rx.sv
`default_nettype none
// ============================================================================
// tb_slow_to_fast_cdc_rx: directed stimulus with a queue-based scoreboard.
// Rev 1.0
// ============================================================================
module tb_slow_to_fast_cdc_rx;

  localparam int DW = 24;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sv;
  logic [DW-1:0] sd;
  logic          rdy;
  logic          oclr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          ovf;
  logic          glitch;
  logic          busy;
  logic [CW-1:0] samp;

  int            errors = 0;
  int            checks = 0;
  int            glitch_cnt = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  slow_to_fast_cdc_rx #(
    .DATA_W(DW), .SYNC_STAGES(2), .SETTLE_CYCLES(2), .CNT_W(CW)
  ) dut (
    .Clk_Fast    (clk),
    .Rst         (rst),
    .Slow_Valid  (sv),
    .Slow_Data   (sd),
    .Out_Ready   (rdy),
    .Overflow_Clr(oclr),
    .Out_Data    (out_data),
    .Out_Valid   (out_valid),
    .Overflow    (ovf),
    .Glitch      (glitch),
    .Busy        (busy),
    .Sample_Cnt  (samp)
  );

  // Every accepted handshake must deliver the oldest expected sample.
  always @(negedge clk) begin
    if (glitch) glitch_cnt++;
    if (!rst && out_valid && rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handshake: got %h, required no pending sample", out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL handshake: got %h, required %h", out_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int hi, input int lo);
    sd = d;
    sv = 1'b1;
    tick(hi);
    sv = 1'b0;
    tick(lo);
  endtask

  initial begin
    rst = 1'b1; sv = 1'b0; sd = '0; rdy = 1'b0; oclr = 1'b0;
    tick(3);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_glitch", 32'(glitch), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(samp), 0);
    rst = 1'b0;
    tick(5);

    // single sample with ready high, latency k+4
    rdy = 1'b1;
    exp_q.push_back(24'hA5A5A5);
    sd = 24'hA5A5A5;
    sv = 1'b1;
    tick(4);
    check("lat_early", 32'(out_valid), 0);
    tick(1);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_data", 32'(out_data), 32'hA5A5A5);
    check("lat_busy", 32'(busy), 1);
    tick(15);
    sv = 1'b0;
    tick(6);
    check("s1_cnt", 32'(samp), 1);
    check("s1_ovf", 32'(ovf), 0);
    check("s1_glitch", 32'(glitch_cnt), 0);
    check("s1_idle", 32'(busy), 0);
    check("s1_drained", 32'(out_valid), 0);

    // valid drops during settle
    send(24'hDEAD00, 2, 8);
    check("gl_count", 32'(glitch_cnt), 1);
    check("gl_valid", 32'(out_valid), 0);
    check("gl_busy", 32'(busy), 0);
    check("gl_cnt", 32'(samp), 1);

    // two samples without ready: second dropped
    rdy = 1'b0;
    exp_q.push_back(24'h111111);
    send(24'h111111, 10, 6);
    send(24'h222222, 10, 6);
    check("ov_data", 32'(out_data), 32'h111111);
    check("ov_valid", 32'(out_valid), 1);
    check("ov_flag", 32'(ovf), 1);
    check("ov_cnt", 32'(samp), 2);
    oclr = 1'b1;
    tick(1);
    oclr = 1'b0;
    check("ov_clr", 32'(ovf), 0);

    // ready on the exact capture edge of a new sample
    exp_q.push_back(24'h333333);
    sd = 24'h333333;
    sv = 1'b1;
    tick(4);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    check("rc_valid", 32'(out_valid), 1);
    check("rc_data", 32'(out_data), 32'h333333);
    check("rc_ovf", 32'(ovf), 0);
    check("rc_cnt", 32'(samp), 3);
    tick(10);
    sv = 1'b0;
    tick(6);
    rdy = 1'b1;
    tick(2);
    rdy = 1'b0;
    check("rc_drained", 32'(out_valid), 0);
    check("rc_queue", 32'(exp_q.size()), 0);

    // valid held high across reset release
    rst = 1'b1;
    sd = 24'h444444;
    sv = 1'b1;
    tick(3);
    exp_q.delete();
    rst = 1'b0;
    tick(10);
    check("hr_busy", 32'(busy), 0);
    check("hr_valid", 32'(out_valid), 0);
    check("hr_cnt", 32'(samp), 0);
    sv = 1'b0;
    tick(10);
    rdy = 1'b1;
    exp_q.push_back(24'h555555);
    send(24'h555555, 10, 6);
    check("hr_cnt2", 32'(samp), 1);
    check("hr_queue", 32'(exp_q.size()), 0);

    // reset during settle
    sd = 24'h666666;
    sv = 1'b1;
    tick(3);
    check("rs_busy", 32'(busy), 1);
    rst = 1'b1;
    sv = 1'b0;
    tick(1);
    check("rs_valid", 32'(out_valid), 0);
    check("rs_busy0", 32'(busy), 0);
    check("rs_cnt", 32'(samp), 0);
    check("rs_ovf", 32'(ovf), 0);
    rst = 1'b0;
    tick(8);
    check("rs_glitch", 32'(glitch_cnt), 1);
    check("rs_valid2", 32'(out_valid), 0);

    // counter wrap after 16 captures
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(24'h700000 + 24'(i));
      send(24'h700000 + 24'(i), 10, 6);
    end
    check("wr_cnt", 32'(samp), 0);
    check("wr_queue", 32'(exp_q.size()), 0);
    check("wr_valid", 32'(out_valid), 0);
    check("wr_ovf", 32'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
